// File: rtl/operand_loader.sv
// Byte-serial operand loader for the Circuit1 datapath: fills a shadow a/b/c
// triplet, commits it atomically, holds it to settle, then presents and awaits ack.
module operand_loader #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic             res_valid,
  input  logic             res_ack,
  output logic             busy,
  output logic [CNT_W-1:0] commit_count
);

  localparam int unsigned HOLD_W = 4;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    SETTLE  = 2'd1,
    PRESENT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]  sh_a, sh_b, sh_c;
  logic [1:0]        idx_q;
  logic              shadow_full_q;
  logic              commit_c;
  logic              accept_c;

  // A full shadow blocks further bytes until it has been committed.
  assign in_ready = !shadow_full_q;
  assign accept_c = in_valid & ~shadow_full_q & ~clr;

  // Presentation state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= EMPTY;
      cnt_q     <= '0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      res_valid <= (state_d == PRESENT);
      busy      <= (state_d != EMPTY);
    end
  end

  // Next-state and commit decision
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    commit_c = 1'b0;
    if (clr) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (shadow_full_q) commit_c = 1'b1;
        end
        SETTLE: begin
          cnt_d = cnt_q - HOLD_W'(1);
          if (cnt_q == HOLD_W'(1)) state_d = PRESENT;
        end
        PRESENT: begin
          if (res_ack) begin
            if (shadow_full_q) commit_c = 1'b1;
            else               state_d  = EMPTY;
          end
        end
        default: state_d = EMPTY;
      endcase
      // Back-to-back commit drops res_valid and restarts settling on the same edge.
      if (commit_c) begin
        state_d = SETTLE;
        cnt_d   = HOLD_W'(HOLD_CYCLES);
      end
    end
  end

  // Shadow triplet fill
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_a          <= '0;
      sh_b          <= '0;
      sh_c          <= '0;
      idx_q         <= 2'd0;
      shadow_full_q <= 1'b0;
    end else if (clr) begin
      idx_q         <= 2'd0;
      shadow_full_q <= 1'b0;
    end else begin
      if (commit_c) shadow_full_q <= 1'b0;
      if (accept_c) begin
        unique case (idx_q)
          2'd0:    sh_a <= in_data;
          2'd1:    sh_b <= in_data;
          default: sh_c <= in_data;
        endcase
        if (idx_q == 2'd2) begin
          idx_q         <= 2'd0;
          shadow_full_q <= 1'b1;
        end else begin
          idx_q <= idx_q + 2'd1;
        end
      end
    end
  end

  // Committed operands; untouched by clr so the datapath inputs never glitch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a            <= '0;
      b            <= '0;
      c            <= '0;
      commit_count <= '0;
    end else if (commit_c) begin
      a            <= sh_a;
      b            <= sh_b;
      c            <= sh_c;
      commit_count <= commit_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_operand_loader.sv
// Scoreboard bench for operand_loader: a queue-based reference model predicts
// each presented triplet; a negedge monitor checks outputs and presentations.
module tb_operand_loader;

  localparam int unsigned W = 8;
  localparam int unsigned H = 2;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a, b, c;
  logic          res_valid;
  logic          res_ack = 1'b0;
  logic          busy;
  logic [CW-1:0] commit_count;

  operand_loader #(.WIDTH(W), .HOLD_CYCLES(H), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .a(a), .b(b), .c(c), .res_valid(res_valid),
    .res_ack(res_ack), .busy(busy), .commit_count(commit_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: shadow as a byte queue, presentation as phase + countdown.
  typedef struct {
    logic [W-1:0]  ea, eb, ec;
    logic [CW-1:0] ecc;
    int            due;
  } exp_t;

  exp_t          sbq[$];
  logic [W-1:0]  sh[$];
  int            phase;      // 0 idle, 1 settling, 2 presenting
  int            tleft;
  logic [W-1:0]  ma, mb, mc;
  logic [CW-1:0] mcc;
  int            cycle;
  int            n_commit;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh.delete(); sbq.delete();
      phase = 0; tleft = 0; ma = '0; mb = '0; mc = '0; mcc = '0;
      cycle = 0; n_commit = 0;
    end else begin
      int  old;
      bit  commit;
      cycle++;
      old = phase;
      if (clr) begin
        sh.delete(); sbq.delete(); phase = 0;
      end else begin
        commit = (sh.size() == 3) && (old == 0 || (old == 2 && res_ack));
        if (old == 1) begin
          tleft--;
          if (tleft == 0) phase = 2;
        end
        if (old == 2 && res_ack) phase = 0;
        if (commit) begin
          ma = sh[0]; mb = sh[1]; mc = sh[2];
          sh.delete();
          mcc = mcc + 1'b1;
          n_commit++;
          phase = 1; tleft = H;
          sbq.push_back('{ea: ma, eb: mb, ec: mc, ecc: mcc, due: cycle + H});
        end else if (in_valid && sh.size() < 3) begin
          sh.push_back(in_data);
        end
      end
    end
  end

  // Monitor: per-cycle output check plus scoreboard pop on each new presentation.
  logic prev_v = 1'b0;
  bit   seen_pulse = 1'b0;
  int   low_run = 0;

  always @(negedge clk) begin
    if (!rst) begin
      prev_v = 1'b0; seen_pulse = 1'b0; low_run = 0;
    end else begin
      chk("in_ready", 32'(in_ready), 32'(sh.size() < 3));
      chk("res_valid", 32'(res_valid), 32'(phase == 2));
      chk("busy", 32'(busy), 32'(phase != 0));
      chk("abc", {8'h00, a, b, c}, {8'h00, ma, mb, mc});
      if (res_valid && !prev_v) begin
        if (seen_pulse) chk("gap_low", 32'(low_run >= int'(H)), 32'd1);
        if (sbq.size() == 0) begin
          chk("sb_nonempty", 32'd0, 32'd1);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("sb_triplet", {8'h00, a, b, c}, {8'h00, e.ea, e.eb, e.ec});
          chk("sb_count", 32'(commit_count), 32'(e.ecc));
          chk("sb_latency", 32'(cycle), 32'(e.due));
        end
        seen_pulse = 1'b1;
        low_run = 0;
      end
      if (!res_valid) low_run++;
      prev_v = res_valid;
    end
  end

  task automatic step(input logic v, input logic [W-1:0] d, input logic k, input logic cl);
    in_valid = v; in_data = d; res_ack = k; clr = cl;
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; res_ack = 1'b0; clr = 1'b0;
    rst = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    int guard;
    #1 rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(commit_count), 32'd0);
    @(negedge clk); @(negedge clk); #1;
    rst = 1'b1;

    // Basic triplet
    step(1'b1, 8'h12, 1'b0, 1'b0);
    step(1'b1, 8'h05, 1'b0, 1'b0);
    step(1'b1, 8'h04, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("basic_abc", {8'h00, a, b, c}, 32'h00120504);
    chk("basic_settle_valid", 32'(res_valid), 32'd0);
    // Back-to-back load during settle
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    step(1'b1, 8'h01, 1'b0, 1'b0);
    chk("basic_valid", 32'(res_valid), 32'd1);
    chk("basic_count", 32'(commit_count), 32'd1);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    chk("b2b_full", 32'(in_ready), 32'd0);
    // Backpressure
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'hAA, 1'b0, 1'b0);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_abc", {8'h00, a, b, c}, 32'h00120504);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("b2b_drop", 32'(res_valid), 32'd0);
    chk("b2b_abc", {8'h00, a, b, c}, 32'h00FF01FF);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("b2b_valid", 32'(res_valid), 32'd1);
    chk("b2b_count", 32'(commit_count), 32'd2);

    // Partial triplet discarded by clr
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    step(1'b1, 8'h44, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b1);
    step(1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b1, 8'h02, 1'b0, 1'b0);
    step(1'b1, 8'h03, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("clr_abc", {8'h00, a, b, c}, 32'h00010203);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("clr_valid", 32'(res_valid), 32'd1);
    chk("clr_count", 32'(commit_count), 32'd3);

    // Asynchronous reset while presenting
    #2 rst = 1'b0;
    #1;
    chk("areset_valid", 32'(res_valid), 32'd0);
    chk("areset_abc", {8'h00, a, b, c}, 32'd0);
    chk("areset_busy", 32'(busy), 32'd0);
    chk("areset_in_ready", 32'(in_ready), 32'd1);
    chk("areset_count", 32'(commit_count), 32'd0);
    @(negedge clk); #1;
    rst = 1'b1;

    // Random traffic with occasional clr
    for (int i = 0; i < 2000; i++) begin
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 63) == 0));
    end

    // Wrap of commit_count with immediate ack
    do_reset();
    guard = 0;
    while (n_commit < 256 && guard < 4000) begin
      step(1'b1, 8'($urandom), 1'b1, 1'b0);
      guard++;
    end
    chk("wrap_reached", 32'(n_commit), 32'd256);
    chk("wrap_count", 32'(commit_count), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/operand_loader.md
Name: operand_loader

Overview:
Upstream feeder for the Circuit1 arithmetic datapath. It accepts a byte-serial operand stream over a valid/ready handshake and assembles a, b, c triplets in a shadow buffer. It commits each triplet atomically to the datapath operand outputs and holds them stable for the datapath's registered result x to settle. It then signals result-valid and waits for the consumer's acknowledge. Double buffering lets the next triplet load while the current one is presented.

Parameters:
WIDTH, 8, operand width of in_data, a, b, c.
HOLD_CYCLES, 2, clock edges from commit to res_valid; legal range 1..15. The datapath needs at least 1 (x is registered).
CNT_W, 8, width of commit_count.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
clr  input  1  synchronous clear; discards the shadow triplet and presentation state.
in_data  input  WIDTH  operand byte; order a, then b, then c.
in_valid  input  1  in_data valid.
in_ready  output  1  loader can accept a byte.
a  output  WIDTH  committed operand a, to the datapath.
b  output  WIDTH  committed operand b.
c  output  WIDTH  committed operand c.
res_valid  output  1  the datapath outputs x/z correspond to the current a, b, c.
res_ack  input  1  consumer has taken the result.
busy  output  1  state != EMPTY.
commit_count  output  CNT_W  number of committed triplets, wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst=0, asynchronous):
  - a, b, c, shadow registers and commit_count clear to 0.
  - idx clears to 0; shadow_full clears to 0.
  - state = EMPTY; res_valid = 0; busy = 0.
  - in_ready = 1, both during and after reset.
- Shadow fill:
  - in_ready = !shadow_full (combinational).
  - A byte transfers when in_valid & in_ready at a rising edge. It is written to shadow[idx], and idx advances 0→1→2.
  - The transfer at idx=2 sets shadow_full=1 and returns idx to 0.
  - in_data is ignored when in_valid=0 or in_ready=0.
- Commit condition: shadow_full & (state==EMPTY | (state==PRESENT & res_ack)). On commit:
  - a, b, c load from the shadow together.
  - shadow_full clears.
  - cnt loads HOLD_CYCLES; state goes to SETTLE.
  - commit_count increments.
  - a, b, c change only on commit, clr does not touch them, and otherwise they hold their values indefinitely.
- States:
  - EMPTY: res_valid=0. Commits when shadow_full=1.
  - SETTLE: cnt decrements each edge. The edge where cnt==1 moves to PRESENT. res_valid=0 throughout.
  - PRESENT: res_valid=1 and the state holds until res_ack=1. On ack, commit back-to-back if shadow_full, otherwise go to EMPTY. res_ack is ignored outside PRESENT.
- Latency:
  - res_valid rises exactly HOLD_CYCLES edges after the commit edge.
  - From an EMPTY start, the commit occurs on the edge after the third byte transfer. First res_valid is therefore HOLD_CYCLES+1 edges after the c byte.
- Back-to-back: if res_ack arrives while shadow_full=1, then on the same edge res_valid drops, the new triplet commits and state becomes SETTLE. res_valid never remains high across two different triplets.
- clr (synchronous, highest priority after reset):
  - Sets idx=0, shadow_full=0, state=EMPTY, res_valid=0.
  - No commit occurs and no byte is accepted on that edge, even if in_valid=1.
  - commit_count is unchanged.
- Partial triplet: idx persists indefinitely between bytes; there is no timeout.
- Reset mid-operation: all state is lost immediately and the partial shadow is discarded.

Test Plan:
- Basic: rst pulse, then bytes 0x12, 0x05, 0x04 on consecutive cycles with res_ack=0.
  - a=0x12, b=0x05, c=0x04 one edge after the c byte.
  - res_valid=1 two edges later (HOLD_CYCLES=2).
  - Datapath x reads 0x0031 and commit_count=1.
- Back-to-back: during SETTLE, load 0xFF, 0x01, 0xFF; in_ready then drops to 0. Pulse res_ack in PRESENT.
  - On the same edge, res_valid=0 and a/b/c = 0xFF/0x01/0xFF.
  - res_valid returns after 2 edges; commit_count=2.
- Backpressure: with shadow_full=1 and PRESENT unacked, hold in_valid=1 with 0xAA for 10 cycles.
  - in_ready=0 throughout, no byte is taken, and a/b/c are unchanged.
- Partial plus clr: send 0x33, 0x44, then clr=1 together with in_valid=1 and data 0x55. Then send 0x01, 0x02, 0x03.
  - The commit yields a=0x01, b=0x02, c=0x03; 0x55 is dropped.
- Async reset in PRESENT: assert rst=0 mid-cycle.
  - res_valid, a, b, c, busy go to 0 immediately, before the next edge.
  - in_ready=1 and commit_count=0.
- Wrap: 256 triplets with immediate ack → commit_count wraps to 0x00; each res_valid pulse is separated by ≥HOLD_CYCLES edges low.
